// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: scanout read port, pixel write port,
// single-port VRAM command/data signals and the write starvation flag.
interface vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) ();

  // Scanout read port
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  // Pixel write port
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // VRAM port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              wr_starved;

  // Arbiter side
  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output rd_data, rd_valid, wr_ready, mem_en, mem_we, mem_addr,
    output mem_wdata, wr_starved
  );

  // Requester / memory side
  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  rd_data, rd_valid, wr_ready, mem_en, mem_we, mem_addr,
    input  mem_wdata, wr_starved
  );

endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter. Scanout reads always win the port and return
// with a fixed latency; pixel writes are buffered in a small FIFO and drained
// into cycles without a read. A saturating counter flags a write buffer that
// has been waiting too long for a free slot.
module vram_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  vram_arbiter_if.slave  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  // Port command register states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  // Write buffer storage (data only, never reset)
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  // FIFO control
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  // Port command register
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Read return stage
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Starvation tracking
  logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              wr_starved_q, wr_starved_d;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle cannot be used to admit a push into a full buffer.
  assign fifo_empty   = (count_q == '0);
  assign bus.wr_ready = rst_n && (count_q < FULL_CNT);

  // FIFO push/pop decisions and pointer/count update
  always_comb begin
    push     = bus.wr_valid && bus.wr_ready;
    // Pop only entries already registered: no same-cycle bypass to the port.
    pop      = !bus.rd_req && !fifo_empty;
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Arbitration: read wins, otherwise drain the FIFO head, otherwise idle
  always_comb begin
    state_d     = ST_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (bus.rd_req) begin
      state_d    = ST_RD;
      mem_addr_d = bus.rd_addr;
    end else if (pop) begin
      state_d     = ST_WR;
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_data_q[rd_ptr_q];
    end
  end

  // Read return: VRAM data arrives the cycle after a read command
  always_comb begin
    rd_valid_d = (state_q == ST_RD);
    rd_data_d  = rd_valid_d ? bus.mem_rdata : rd_data_q;
  end

  // Starvation counter: counts cycles with a waiting entry and no drain
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + STV_W'(1);
    end
    wr_starved_d = (starve_cnt_d == STARVE_MAX);
  end

  // Write buffer storage capture at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      starve_cnt_q <= '0;
      wr_starved_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      starve_cnt_q <= starve_cnt_d;
      wr_starved_q <= wr_starved_d;
    end
  end

  assign bus.mem_en     = (state_q != ST_IDLE);
  assign bus.mem_we     = (state_q == ST_WR);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.wr_starved = wr_starved_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed stimulus, scoreboard queues for read
// returns and VRAM writes, and a negedge monitor that pops and compares.
module tb_vram_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .STARVE_LIMIT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // VRAM model: asynchronous read of the registered command address,
  // write on the clock edge. Unwritten locations hold a fixed pattern.
  bit [DW-1:0] vmem  [0:(1<<AW)-1];
  bit          wflag [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (a == 15'h0123) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  assign bus.mem_rdata = wflag[bus.mem_addr] ? vmem[bus.mem_addr] : pat(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
      vmem[bus.mem_addr]  <= bus.mem_wdata;
      wflag[bus.mem_addr] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int c; } rd_exp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  rd_exp_t rdq[$];
  wr_t     srcq[$];
  wr_t     wrq[$];

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every read return and every VRAM write command
  rd_exp_t mon_r;
  wr_t     mon_w;
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (rdq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual data=0x%0h required=no rd_valid (cycle %0d)",
                 bus.rd_data, cyc);
      end else begin
        mon_r = rdq.pop_front();
        chk("rd_data", bus.rd_data, mon_r.d);
        chk("rd_latency", cyc, mon_r.c);
      end
    end
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
      we_cnt++;
      if (wrq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual addr=0x%0h data=0x%0h required=no write (cycle %0d)",
                 bus.mem_addr, bus.mem_wdata, cyc);
      end else begin
        mon_w = wrq.pop_front();
        chk("wr_addr", bus.mem_addr, mon_w.a);
        chk("wr_data", bus.mem_wdata, mon_w.d);
      end
    end
  end

  task automatic add_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    srcq.push_back(w);
  endtask

  // One clock of stimulus; starts and ends 1 time unit after a rising edge
  task automatic tick(input logic rd, input logic [AW-1:0] ra,
                      input logic [DW-1:0] ed, input bit exp);
    rd_exp_t e;
    bit acc;
    bus.rd_req  = rd;
    bus.rd_addr = ra;
    if (srcq.size() > 0) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = srcq[0].a;
      bus.wr_data  = srcq[0].d;
    end else begin
      bus.wr_valid = 1'b0;
    end
    #2;
    acc = bus.wr_valid && (bus.wr_ready === 1'b1);
    if (rd && exp) begin
      e.d = ed;
      e.c = cyc + 2;
      rdq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (acc) wrq.push_back(srcq.pop_front());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, '0, '0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"},     bus.mem_en,     0);
    chk({tag, "_mem_we"},     bus.mem_we,     0);
    chk({tag, "_mem_addr"},   bus.mem_addr,   0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata,  0);
    chk({tag, "_rd_data"},    bus.rd_data,    0);
    chk({tag, "_rd_valid"},   bus.rd_valid,   0);
    chk({tag, "_wr_starved"}, bus.wr_starved, 0);
    chk({tag, "_wr_ready"},   bus.wr_ready,   0);
  endtask

  initial begin
    int base;
    logic [AW-1:0] ra;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    @(posedge clk);
    #1;

    // Reset and release
    rst_n = 1'b0;
    idle(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("rst_release_wr_ready", bus.wr_ready, 1);
    idle(1);

    // Single read of 0x0123
    tick(1'b1, 15'h0123, 8'hA5, 1'b1);
    chk("rd_cmd_en", bus.mem_en, 1);
    chk("rd_cmd_we", bus.mem_we, 0);
    chk("rd_cmd_addr", bus.mem_addr, 15'h0123);
    idle(1);
    chk("rd_cmd_done_en", bus.mem_en, 0);
    idle(3);

    // Push into an empty FIFO with no read: no same-cycle bypass
    add_wr(15'h0050, 8'h11);
    tick(1'b0, '0, '0, 1'b0);
    chk("nobypass_en", bus.mem_en, 0);
    idle(1);
    chk("wr1_en", bus.mem_en, 1);
    chk("wr1_we", bus.mem_we, 1);
    chk("wr1_addr", bus.mem_addr, 15'h0050);
    chk("wr1_wdata", bus.mem_wdata, 8'h11);
    idle(1);
    chk("idle_en", bus.mem_en, 0);
    chk("idle_addr_hold", bus.mem_addr, 15'h0050);
    chk("idle_wdata_hold", bus.mem_wdata, 8'h11);

    // Fill the buffer while reads hold the port every cycle
    add_wr(15'h0300, 8'h77);
    add_wr(15'h0301, 8'h12);
    add_wr(15'h0302, 8'h34);
    add_wr(15'h0303, 8'h56);
    base = we_cnt;
    for (int i = 0; i < 70; i++) begin
      ra = (i == 5) ? 15'h0300 : (15'h0200 + 15'(i));
      tick(1'b1, ra, pat(ra), 1'b1);
      if (i == 3)  chk("fill_wr_ready", bus.wr_ready, 0);
      if (i == 19) chk("fill_starved_early", bus.wr_starved, 0);
    end
    chk("fill_starved", bus.wr_starved, 1);
    chk("fill_no_we", we_cnt - base, 0);
    base = we_cnt;
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, '0, '0, 1'b0);
      chk("drain_we", bus.mem_we, 1);
      if (j == 0) begin
        chk("drain_wr_ready", bus.wr_ready, 1);
        chk("drain_starved", bus.wr_starved, 0);
      end
    end
    idle(1);
    chk("drain_en_after", bus.mem_en, 0);
    chk("drain_we_count", we_cnt - base, 4);
    tick(1'b1, 15'h0300, 8'h77, 1'b1);
    idle(3);

    // Push against a full buffer in the same cycle as a pop
    for (int k = 0; k < 5; k++) add_wr(15'h0310 + 15'(k), 8'hB0 + 8'(k));
    for (int i = 0; i < 6; i++) begin
      ra = 15'h0240 + 15'(i);
      tick(1'b1, ra, pat(ra), 1'b1);
    end
    chk("full_wr_ready", bus.wr_ready, 0);
    tick(1'b0, '0, '0, 1'b0);
    chk("full_pop_wr_ready", bus.wr_ready, 1);
    chk("full_pop_rejected", srcq.size(), 1);
    tick(1'b0, '0, '0, 1'b0);
    chk("full_next_accepted", srcq.size(), 0);
    idle(6);

    // Reads every other cycle with continuous writes
    for (int k = 0; k < 8; k++) add_wr(15'h0320 + 15'(k), 8'hC0 + 8'(k));
    for (int i = 0; i < 16; i++) begin
      ra = 15'h0260 + 15'(i);
      tick((i % 2) == 0, ra, pat(ra), 1'b1);
      if (i >= 1) chk("ilv_we", bus.mem_we, ((i % 2) == 0) ? 0 : 1);
    end
    idle(4);

    // Reset with two reads in flight and three buffered writes
    add_wr(15'h0330, 8'hD0);
    add_wr(15'h0331, 8'hD1);
    add_wr(15'h0332, 8'hD2);
    for (int i = 0; i < 5; i++) begin
      ra = 15'h0280 + 15'(i);
      tick(1'b1, ra, pat(ra), 1'b1);
    end
    chk("pre_rst_buffered", wrq.size(), 3);
    tick(1'b1, 15'h0290, '0, 1'b0);
    rst_n = 1'b0;
    tick(1'b1, 15'h0291, '0, 1'b0);
    wrq.delete();
    tick(1'b0, '0, '0, 1'b0);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    #1;
    chk("midrst_release_wr_ready", bus.wr_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, '0, '0, 1'b0);
      chk("post_rst_en", bus.mem_en, 0);
    end
    idle(2);

    chk("rd_queue_empty", rdq.size(), 0);
    chk("wr_queue_empty", wrq.size(), 0);
    chk("src_queue_empty", srcq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
